// File: rtl/fetch_sequencer_pkg.sv
// Shared arm32 fetch constants: state encodings, code memory geometry and
// instruction size.
package fetch_sequencer_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t StIdle  = 2'd0;
    localparam fetch_state_t StRun   = 2'd1;
    localparam fetch_state_t StHalt  = 2'd2;
    localparam fetch_state_t StFault = 2'd3;

    // Must track the fetch stage's code_addr_width.
    localparam int unsigned CodeAddrWidthDefault = 8;

    localparam logic [31:0] InstBytes = 32'd4;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + InstBytes;
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational legality check for a code fetch address: word aligned and
// inside the 2^CODE_ADDR_WIDTH-word code memory.
module fetch_addr_check
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned CODE_ADDR_WIDTH = CodeAddrWidthDefault
) (
    input  logic [31:0] addr,
    output logic        legal
);

    logic aligned;
    logic in_range;

    always_comb begin
        aligned  = (addr[1:0] == 2'b00);
        in_range = ((addr >> (CODE_ADDR_WIDTH + 2)) == 32'd0);
        legal    = aligned && in_range;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC and run/halt/fault state, applies branch
// redirects and decode back-pressure, and tags the fetch->decode register.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned CODE_ADDR_WIDTH = CodeAddrWidthDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        fetch_en,
    output logic [31:0] fetch_pc,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [1:0]  state,
    output logic        fault,
    output logic [31:0] fault_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         dec_valid_q, dec_valid_d;
    logic [31:0]  dec_pc_q, dec_pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic legal;
    logic want;

    fetch_addr_check #(
        .CODE_ADDR_WIDTH(CODE_ADDR_WIDTH)
    ) u_addr_check (
        .addr (fetch_pc),
        .legal(legal)
    );

    // A redirect or a free decode slot lets a new fetch overwrite the register.
    always_comb begin
        fetch_pc = br_taken ? br_target : pc_q;
        want     = (state_q == StRun) && !halt_req &&
                   (br_taken || !dec_valid_q || dec_ready);
        fetch_en = want && legal;
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (want && !legal) begin
                    state_d    = StFault;
                    fault_d    = 1'b1;
                    fault_pc_d = fetch_pc;
                end
            end
            StHalt: begin
                if (start && !halt_req) state_d = StRun;
            end
            StFault: begin
                state_d = StFault;
            end
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        dec_valid_d = dec_valid_q;
        dec_pc_d    = dec_pc_q;

        if (fetch_en) begin
            pc_d        = next_seq_pc(fetch_pc);
            dec_valid_d = 1'b1;
            dec_pc_d    = fetch_pc;
        end else if (br_taken && (state_q != StFault)) begin
            pc_d        = br_target;
            dec_valid_d = 1'b0;
        end else if (dec_valid_q && dec_ready) begin
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            dec_valid_q <= 1'b0;
            dec_pc_q    <= 32'd0;
            fault_q     <= 1'b0;
            fault_pc_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dec_valid_q <= dec_valid_d;
            dec_pc_q    <= dec_pc_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    always_comb begin
        state     = state_q;
        dec_valid = dec_valid_q;
        dec_pc    = dec_pc_q;
        fault     = fault_q;
        fault_pc  = fault_pc_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a one-cycle fetch inst register model.
module tb_fetch_sequencer;

    localparam logic [31:0] InstTag = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] inst_q;

    int n_cmp;
    int n_bad;

    fetch_sequencer #(
        .RESET_PC       (32'h0000_0000),
        .CODE_ADDR_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .halt_req (halt_req),
        .fetch_en (fetch_en),
        .fetch_pc (fetch_pc),
        .dec_valid(dec_valid),
        .dec_pc   (dec_pc),
        .dec_ready(dec_ready),
        .br_taken (br_taken),
        .br_target(br_target),
        .state    (state),
        .fault    (fault),
        .fault_pc (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch stage inst register: loads only when do_fetch is high.
    always @(posedge clk) begin
        if (fetch_en) inst_q <= fetch_pc ^ InstTag;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        halt_req  = 1'b0;
        dec_ready = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;

        // Reset state
        to_neg();
        to_neg();
        check_eq("rst_state", state, 32'd0);
        check_eq("rst_dec_valid", dec_valid, 32'd0);
        check_eq("rst_dec_pc", dec_pc, 32'd0);
        check_eq("rst_fault", fault, 32'd0);
        check_eq("rst_fault_pc", fault_pc, 32'd0);
        check_eq("rst_fetch_pc", fetch_pc, 32'd0);
        check_eq("rst_fetch_en", fetch_en, 32'd0);
        to_pos();
        rst_n = 1'b1;

        // Start cycle: no fetch yet
        start     = 1'b1;
        dec_ready = 1'b1;
        to_neg();
        check_eq("start_cycle_fetch_en", fetch_en, 32'd0);
        to_pos();
        start = 1'b0;

        // Sequential fetch 0,4,8; dec_pc lags by one cycle
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check_eq("seq_state", state, 32'd1);
            check_eq("seq_fetch_en", fetch_en, 32'd1);
            check_eq("seq_fetch_pc", fetch_pc, 32'(i * 4));
            check_eq("seq_dec_valid", dec_valid, (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check_eq("seq_dec_pc", dec_pc, 32'((i - 1) * 4));
            to_pos();
        end

        // Stall three cycles holding dec_pc=8
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check_eq("stall_fetch_en", fetch_en, 32'd0);
            check_eq("stall_dec_pc", dec_pc, 32'd8);
            check_eq("stall_dec_valid", dec_valid, 32'd1);
            check_eq("stall_inst", inst_q, 32'd8 ^ InstTag);
            to_pos();
        end
        dec_ready = 1'b1;
        to_neg();
        check_eq("release_fetch_en", fetch_en, 32'd1);
        check_eq("release_fetch_pc", fetch_pc, 32'd12);
        to_pos();
        to_neg();
        check_eq("post_release_dec_pc", dec_pc, 32'd12);
        check_eq("post_release_fetch_pc", fetch_pc, 32'd16);
        to_pos();

        // Branch while dec_pc=0x10, decode not accepting
        dec_ready = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h40;
        to_neg();
        check_eq("br_dec_pc_before", dec_pc, 32'h10);
        check_eq("br_fetch_pc", fetch_pc, 32'h40);
        check_eq("br_fetch_en", fetch_en, 32'd1);
        to_pos();
        br_taken  = 1'b0;
        dec_ready = 1'b1;
        to_neg();
        check_eq("br_dec_pc_after", dec_pc, 32'h40);
        check_eq("br_dec_valid_after", dec_valid, 32'd1);
        check_eq("br_inst_after", inst_q, 32'h40 ^ InstTag);
        check_eq("br_next_fetch_pc", fetch_pc, 32'h44);
        to_pos();

        // halt_req + start together in RUN -> HALT; pending 0x44 drains
        halt_req  = 1'b1;
        start     = 1'b1;
        dec_ready = 1'b0;
        to_neg();
        check_eq("halt_fetch_en", fetch_en, 32'd0);
        check_eq("halt_pending_pc", dec_pc, 32'h44);
        to_pos();
        halt_req  = 1'b0;
        start     = 1'b0;
        dec_ready = 1'b1;
        to_neg();
        check_eq("halt_state", state, 32'd2);
        check_eq("halt_pending_valid", dec_valid, 32'd1);
        check_eq("halt_drain_fetch_en", fetch_en, 32'd0);
        to_pos();
        to_neg();
        check_eq("halt_drained", dec_valid, 32'd0);
        to_pos();
        start = 1'b1;
        to_neg();
        check_eq("halt_start_cycle_state", state, 32'd2);
        to_pos();
        start = 1'b0;
        to_neg();
        check_eq("resume_state", state, 32'd1);
        check_eq("resume_fetch_pc", fetch_pc, 32'h48);
        check_eq("resume_fetch_en", fetch_en, 32'd1);
        to_pos();

        // Last code word 0x3FC fetches, then sequential 0x400 faults
        br_taken  = 1'b1;
        br_target = 32'h3F8;
        to_neg();
        check_eq("edge_br_fetch_en", fetch_en, 32'd1);
        to_pos();
        br_taken = 1'b0;
        to_neg();
        check_eq("last_word_fetch_pc", fetch_pc, 32'h3FC);
        check_eq("last_word_fetch_en", fetch_en, 32'd1);
        to_pos();
        to_neg();
        check_eq("over_fetch_pc", fetch_pc, 32'h400);
        check_eq("over_fetch_en", fetch_en, 32'd0);
        check_eq("over_dec_pc", dec_pc, 32'h3FC);
        to_pos();
        start = 1'b1;
        to_neg();
        check_eq("oob_state", state, 32'd3);
        check_eq("oob_fault", fault, 32'd1);
        check_eq("oob_fault_pc", fault_pc, 32'h400);
        check_eq("oob_fetch_en", fetch_en, 32'd0);
        check_eq("oob_drained", dec_valid, 32'd0);
        to_pos();
        start = 1'b0;
        to_neg();
        check_eq("oob_sticky_state", state, 32'd3);
        to_pos();

        // Reset out of FAULT
        rst_n = 1'b0;
        to_neg();
        check_eq("rst2_state", state, 32'd0);
        check_eq("rst2_fault", fault, 32'd0);
        check_eq("rst2_fetch_pc", fetch_pc, 32'd0);
        to_pos();
        rst_n = 1'b1;

        // Misaligned branch target faults immediately
        start = 1'b1;
        to_pos();
        start     = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h22;
        to_neg();
        check_eq("mis_fetch_pc", fetch_pc, 32'h22);
        check_eq("mis_fetch_en", fetch_en, 32'd0);
        to_pos();
        br_target = 32'h80;
        to_neg();
        check_eq("mis_state", state, 32'd3);
        check_eq("mis_fault_pc", fault_pc, 32'h22);
        check_eq("mis_fault_br_fetch_en", fetch_en, 32'd0);
        to_pos();
        br_taken = 1'b0;
        start    = 1'b1;
        to_neg();
        check_eq("mis_sticky_state", state, 32'd3);
        to_pos();
        start = 1'b0;
        rst_n = 1'b0;
        to_neg();
        check_eq("mis_rst_state", state, 32'd0);
        check_eq("mis_rst_pc", fetch_pc, 32'd0);
        check_eq("mis_rst_fault_pc", fault_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
